// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its key FIFO.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // FIFO entry layout: {ext, brk, code[7:0]}
  localparam int ENTRY_W = 10;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Read-side handshake of the decoded-key FIFO; master presents entries, slave accepts them.
interface ps2_rx_fifo_if;
  import ps2_pkg::*;

  logic       rd_valid;
  logic [7:0] rd_code;
  logic       rd_ext;
  logic       rd_brk;
  logic       rd_ready;

  modport master (output rd_valid, output rd_code, output rd_ext, output rd_brk, input rd_ready);
  modport slave  (input rd_valid, input rd_code, input rd_ext, input rd_brk, output rd_ready);

endinterface

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO only succeeds alongside a same-cycle pop.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && w_full && !w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the raw lines, decodes 11-bit frames, folds E0/F0
// prefixes into flags and queues the resulting key events in a FWFT FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  ps2_rx_fifo_if.master                 rd,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;

  ps2_state_t    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic          r_ext_pend;
  logic          r_brk_pend;
  logic          r_parity_err;
  logic          r_frame_err;

  logic                w_clk_s;
  logic                w_dat_s;
  logic                w_fall;
  logic                w_timeout;
  logic                w_accept;
  logic                w_push;
  logic [ENTRY_W-1:0]  w_entry;
  logic [ENTRY_W-1:0]  w_head;
  logic                w_valid;

  // Reset to idle-high so releasing reset never fabricates a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s   = r_dat_sync[SYNC_STAGES-1];
  assign w_fall    = r_clk_prev && !w_clk_s;
  assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  assign w_accept = (r_state == ST_STOP) && w_fall && w_dat_s && odd_parity_ok(r_shift, r_parity);
  assign w_push   = w_accept && (r_shift != PS2_EXT) && (r_shift != PS2_BRK);
  assign w_entry  = {r_ext_pend, r_brk_pend, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_ext_pend   <= 1'b0;
      r_brk_pend   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      if (r_state == ST_IDLE || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_brk_pend  <= 1'b0;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_dat_s) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_parity <= w_dat_s;
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_dat_s) begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_brk_pend  <= 1'b0;
            end else if (!odd_parity_ok(r_shift, r_parity)) begin
              r_parity_err <= 1'b1;
              r_ext_pend   <= 1'b0;
              r_brk_pend   <= 1'b0;
            end else if (r_shift == PS2_EXT) begin
              r_ext_pend <= 1'b1;
            end else if (r_shift == PS2_BRK) begin
              r_brk_pend <= 1'b1;
            end else begin
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_push     (w_push),
    .i_data     (w_entry),
    .i_pop      (rd.rd_ready),
    .o_valid    (w_valid),
    .o_data     (w_head),
    .o_count    (fifo_count),
    .o_overflow (overflow)
  );

  assign rd.rd_valid = w_valid;
  assign rd.rd_ext   = w_head[9];
  assign rd.rd_brk   = w_head[8];
  assign rd.rd_code  = w_head[7:0];
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning number of decoded-key entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 5000, meaning clk cycles allowed between PS/2 falling edges inside a frame.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per PS/2 input; minimum 2.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 The block SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 The block SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-009 The block SHALL have port rd_valid  output  1  FIFO non-empty; the head entry is presented.
REQ-010 The block SHALL have port rd_code  output  8  head scan code.
REQ-011 The block SHALL have port rd_ext  output  1  head code was preceded by E0.
REQ-012 The block SHALL have port rd_brk  output  1  head code was preceded by F0 (key release).
REQ-013 The block SHALL have ports parity_err, frame_err and overflow  output  1 each  single-cycle error pulses.
REQ-014 The block SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-015 Both PS/2 inputs SHALL pass through SYNC_STAGES flops; a falling edge SHALL be previous synchronized ps2_clk=1 and current=0, and all sampling SHALL use synchronized ps2_data on that cycle.
REQ-016 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: on an edge with data=0 -> DATA with bit counter 0; on an edge with data=1 -> frame_err pulse, remain IDLE.
REQ-018 DATA: each edge SHALL shift the bit in LSB-first; after the 8th edge -> PARITY.
REQ-019 PARITY: the edge SHALL capture the parity bit -> STOP.
REQ-020 STOP: on the edge, stop=0 -> frame_err pulse; otherwise an even count of ones over the 8 data bits plus parity -> parity_err pulse; otherwise the byte is accepted; every case -> IDLE.
REQ-021 In any non-IDLE state, TIMEOUT_CYC cycles without an edge SHALL pulse frame_err, discard the partial byte, and return to IDLE; the timeout counter SHALL clear on every edge and in IDLE.
REQ-022 An accepted E0 SHALL set ext_pend and an accepted F0 SHALL set brk_pend; neither SHALL be pushed.
REQ-023 Any other accepted byte SHALL be pushed as {ext_pend, brk_pend, code} on the STOP-edge cycle, and both pending flags SHALL clear on that cycle.
REQ-024 parity_err, frame_err or timeout SHALL clear both pending flags.
REQ-025 The FIFO SHALL be first-word-fall-through; rd_valid SHALL rise the cycle after a push into an empty FIFO.
REQ-026 A pop SHALL occur when rd_valid and rd_ready are both 1; the next entry, if any, SHALL appear the following cycle.
REQ-027 When rd_valid=0, rd_code, rd_ext and rd_brk SHALL be 0.
REQ-028 A push when full without a same-cycle pop SHALL drop the new entry, pulse overflow, and leave contents unchanged.
REQ-029 A push and a pop in the same cycle SHALL both occur at any occupancy, including full, without overflow; fifo_count SHALL be unchanged.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.

Reset
REQ-031 With rst_n=0, all outputs SHALL be 0, FSM IDLE, FIFO empty, pointers, counters and pending flags 0.
REQ-032 Synchronizer and edge-history flops SHALL reset to 1, so no edge is detected on release.
REQ-033 Reset mid-frame SHALL discard the partial frame; the remaining bits of that frame SHALL be handled per REQ-017 and REQ-021.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state enum and constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
REQ-035 The FIFO SHALL be sub-module ps2_sync_fifo, parametrised by width (10) and FIFO_DEPTH.

Verification
REQ-036 Frame 0x1C with correct parity, rd_ready=0 -> rd_valid=1, rd_code=1C, rd_ext=0, rd_brk=0, fifo_count=1.
REQ-037 Frames E0, F0, 75 -> single entry: code 75, ext=1, brk=1; pending flags cleared.
REQ-038 Frame 0x1C with wrong parity -> one parity_err pulse, fifo_count stays 0.
REQ-039 Start bit plus 3 data bits, then idle for TIMEOUT_CYC -> frame_err pulse; a following valid 0x29 frame is received correctly.
REQ-040 FIFO_DEPTH+1 frames, rd_ready=0 -> fifo_count=FIFO_DEPTH, one overflow pulse; drain returns the first FIFO_DEPTH codes in order.
REQ-041 FIFO full, rd_ready=1 on the push cycle -> no overflow, fifo_count unchanged, order preserved.
